rf_write_arbiter: RTL

Shares the register file's single write port between two writeback requesters: A is the ALU writeback and B is the load/IO unit. Arbitration is round-robin over a valid/ready handshake. Write address, data and enable are registered onto the register-file write port. Writes to %0 are discarded, and an optional read bypass forwards the in-flight write to the two read ports.

---
 rtl/rf_wr_if.sv | 19 +
 rtl/rf_write_arbiter.sv | 57 +++++
 2 files changed

// File: rtl/rf_wr_if.sv
// rf_wr_if: writeback handshake bundle for the two register-file write requesters.
//   a_valid/a_addr/a_data, b_valid/b_addr/b_data : requester -> arbiter
//   a_ready, b_ready                              : arbiter -> requester (grant)
//   master = requester side, slave = arbiter side.
interface rf_wr_if #(
    parameter int BUS_WIDTH  = 8,
    parameter int ADDR_WIDTH = 5
);
    logic                  a_valid;
    logic                  a_ready;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [BUS_WIDTH-1:0]  a_data;
    logic                  b_valid;
    logic                  b_ready;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [BUS_WIDTH-1:0]  b_data;
    modport master (output a_valid, a_addr, a_data, b_valid, b_addr, b_data, input a_ready, b_ready);
    modport slave  (input a_valid, a_addr, a_data, b_valid, b_addr, b_data, output a_ready, b_ready);
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin share of the register-file write port between A (ALU) and B (load/IO).
//   clk, rst_n (sync, active low), stall : control
//   req (rf_wr_if.slave)                  : A/B valid/ready/addr/data handshakes
//   rf_we, rf_wr_addr, rf_wr_data         : registered register-file write port
//   last_b                                : 1 when B won the most recent grant
//   RF_WR_BYPASS_EN: adds byp_rd_*/byp_rs_* read-port forwarding of the in-flight write.
module rf_write_arbiter #(
    parameter int BUS_WIDTH  = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    rf_wr_if.slave                req,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [BUS_WIDTH-1:0]  rf_wr_data,
    output logic                  last_b
`ifdef RF_WR_BYPASS_EN
    ,
    input  logic [ADDR_WIDTH-1:0] byp_rd_addr,
    input  logic [ADDR_WIDTH-1:0] byp_rs_addr,
    input  logic [BUS_WIDTH-1:0]  byp_rd_in,
    input  logic [BUS_WIDTH-1:0]  byp_rs_in,
    output logic [BUS_WIDTH-1:0]  byp_rd_out,
    output logic [BUS_WIDTH-1:0]  byp_rs_out
`endif
);
    logic gnt_a, gnt_b;
    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        gnt_a = rst_n && !stall && req.a_valid && (!req.b_valid || last_b);
        gnt_b = rst_n && !stall && req.b_valid && (!req.a_valid || !last_b);
    end
    assign req.a_ready = gnt_a;
    assign req.b_ready = gnt_b;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we      <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            last_b     <= 1'b1;
        end else begin
            // %0 writes still complete and latch addr/data, they just never enable.
            rf_we <= gnt_a ? (req.a_addr != '0) : gnt_b ? (req.b_addr != '0) : 1'b0;
            if (gnt_a || gnt_b) begin
                rf_wr_addr <= gnt_a ? req.a_addr : req.b_addr;
                rf_wr_data <= gnt_a ? req.a_data : req.b_data;
                last_b     <= gnt_b;
            end
        end
    end
`ifdef RF_WR_BYPASS_EN
    assign byp_rd_out = (rf_we && rf_wr_addr == byp_rd_addr) ? rf_wr_data : byp_rd_in;
    assign byp_rs_out = (rf_we && rf_wr_addr == byp_rs_addr) ? rf_wr_data : byp_rs_in;
`endif
endmodule
